// File: rtl/div_pkg.sv
// Shared types, sizes and helpers for the sequential signed divider.
package div_pkg;

  // Default operand width; the divider top uses this as its WIDTH default.
  localparam int DIV_WIDTH = 4;

  // Step counter width, wide enough to count the 2*WIDTH quotient bits.
  localparam int CNT_W = $clog2(2 * DIV_WIDTH + 1);

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Magnitude of a 2*DIV_WIDTH-bit signed value, returned one bit wider so
  // that the most negative value still has a representable magnitude.
  function automatic logic [2*DIV_WIDTH:0] abs_ext(input logic [2*DIV_WIDTH-1:0] v);
    logic [2*DIV_WIDTH:0] e;
    e = {v[2*DIV_WIDTH-1], v};
    return e[2*DIV_WIDTH] ? -e : e;
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One combinational restoring-division iteration: shift the partial
// remainder left, bring in the next dividend bit, subtract the divisor
// magnitude when it fits.
module restoring_div_step #(
  parameter int PW = 5
) (
  input  logic [PW-1:0] partial,
  input  logic [PW-1:0] dmag,
  input  logic          bit_in,
  output logic [PW-1:0] next_partial,
  output logic          q_bit
);

  logic [PW-1:0] trial;

  // The partial remainder is always below the divisor magnitude, so its top
  // bit is zero and can be dropped by the shift without losing information.
  always_comb begin
    trial        = PW'({partial, bit_in});
    next_partial = trial;
    q_bit        = 1'b0;
    if (trial >= dmag) begin
      next_partial = trial - dmag;
      q_bit        = 1'b1;
    end
  end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// quotient truncated toward zero, remainder carrying the dividend's sign.
//
// Handshake: start is sampled only in IDLE; the rising edge that sees it
// captures the operands. busy is high while the operation is in progress
// (CALC and FIX), done pulses for exactly one cycle when the registered
// results and flags become valid, and those outputs then hold until the
// next accepted start. start while busy is dropped, never queued.
module booth_seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               overflow,
  output state_t             fsm_state
);

  localparam int DW = 2 * WIDTH;
  localparam int PW = WIDTH + 1;
  localparam int CW = CNT_W;
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  state_t state_q, state_d;

  logic [CW-1:0] cnt_q;
  logic [DW-1:0] dvd_sh_q;   // dividend magnitude, consumed MSB first
  logic [DW-1:0] q_sh_q;     // quotient magnitude, built LSB last
  logic [PW-1:0] part_q;     // partial remainder
  logic [PW-1:0] dmag_q;     // divisor magnitude
  logic          neg_q_q;    // quotient needs negating
  logic          neg_r_q;    // remainder needs negating
  logic          dz_q;
  logic          ovf_q;

  logic [DW-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic          div_by_zero_q;
  logic          overflow_q;

  logic [DW:0]   dvd_mag;
  logic [PW-1:0] dsr_sx;
  logic [PW-1:0] dsr_mag;
  logic          is_min_dvd;
  logic [PW-1:0] step_part;
  logic          step_q;
  logic [DW-1:0] q_signed;

  // Operand magnitudes and special-case detection at capture time.
  always_comb begin
    dvd_mag    = abs_ext(dividend);
    dsr_sx     = {divisor[WIDTH-1], divisor};
    dsr_mag    = dsr_sx[PW-1] ? -dsr_sx : dsr_sx;
    is_min_dvd = (dvd_mag == {2'b01, {(DW-1){1'b0}}}) && dividend[DW-1];
    q_signed   = neg_q_q ? -q_sh_q : q_sh_q;
  end

  restoring_div_step #(.PW(PW)) u_step (
    .partial      (part_q),
    .dmag         (dmag_q),
    .bit_in       (dvd_sh_q[DW-1]),
    .next_partial (step_part),
    .q_bit        (step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed-length walk IDLE -> CALC x 2*WIDTH -> FIX -> DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == LAST_CNT) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, one quotient bit per CALC cycle, sign fix-up
  // and result registration in FIX.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      dvd_sh_q      <= '0;
      q_sh_q        <= '0;
      part_q        <= '0;
      dmag_q        <= '0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      dz_q          <= 1'b0;
      ovf_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q         <= '0;
            dvd_sh_q      <= DW'(dvd_mag);
            q_sh_q        <= '0;
            part_q        <= '0;
            dmag_q        <= dsr_mag;
            neg_q_q       <= dividend[DW-1] ^ divisor[WIDTH-1];
            neg_r_q       <= dividend[DW-1];
            dz_q          <= (divisor == '0);
            ovf_q         <= is_min_dvd && (divisor == '1);
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
          end
        end
        CALC: begin
          part_q   <= step_part;
          q_sh_q   <= {q_sh_q[DW-2:0], step_q};
          dvd_sh_q <= {dvd_sh_q[DW-2:0], 1'b0};
          cnt_q    <= cnt_q + CW'(1);
        end
        FIX: begin
          div_by_zero_q <= dz_q;
          overflow_q    <= ovf_q && !dz_q;
          if (dz_q) begin
            quotient_q  <= '0;
            remainder_q <= '0;
          end else if (ovf_q) begin
            quotient_q  <= {1'b1, {(DW-1){1'b0}}};
            remainder_q <= '0;
          end else begin
            quotient_q  <= q_signed;
            remainder_q <= WIDTH'(neg_r_q ? -part_q : part_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed and round-trip bench for booth_seq_divider (WIDTH = 4).
module tb_booth_seq_divider;
  import div_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic       overflow;
  state_t     fsm_state;

  always #5 clk = ~clk;

  booth_seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .fsm_state   (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] exp_q[$];   // {quotient[7:0], remainder[3:0], div_by_zero, overflow}

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Launch one division and wait for done. cyc is the cycle index of the
  // done cycle, counting the cycle right after the start edge as 1.
  task automatic run_div(input logic [7:0] a, input logic [3:0] b,
                         output int cyc, output bit busy_ok, output bit pulse_ok,
                         output logic [7:0] q, output logic [3:0] r,
                         output logic dz, output logic ov);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    cyc     = 1;
    busy_ok = 1'b1;
    while (cyc < 40 && !done) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    q  = quotient;
    r  = remainder;
    dz = div_by_zero;
    ov = overflow;
    if (done && busy) busy_ok = 1'b0;
    @(posedge clk);
    #1;
    pulse_ok = !done;
  endtask

  task automatic do_case(input string tag, input logic [7:0] a, input logic [3:0] b,
                         input int eq, input int er, input logic edz, input logic eov);
    int cyc;
    bit busy_ok, pulse_ok;
    logic [7:0] q;
    logic [3:0] r;
    logic dz, ov;
    logic [7:0] eq8;
    logic [3:0] er4;
    logic [13:0] e;
    eq8 = eq[7:0];
    er4 = er[3:0];
    exp_q.push_back({eq8, er4, edz, eov});
    run_div(a, b, cyc, busy_ok, pulse_ok, q, r, dz, ov);
    e = exp_q.pop_front();
    check({tag, "_lat"}, cyc, 10);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_pulse"}, pulse_ok, 1);
    check({tag, "_q"}, $signed(q), $signed(e[13:6]));
    check({tag, "_r"}, $signed(r), $signed(e[5:2]));
    check({tag, "_dz"}, dz, e[1]);
    check({tag, "_ov"}, ov, e[0]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, n_done, ai, bi, qi, ri;
    bit busy_ok, pulse_ok;
    logic [7:0] q, a8, p8, seen_q;
    logic [3:0] r, b4, seen_r;
    logic dz, ov;
    logic signed [7:0] a_s;
    logic signed [3:0] b_s;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_by_zero, 0);
    check("rst_ov", overflow, 0);
    check("rst_state", fsm_state, IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors, expectations computed by hand.
    do_case("d21_3",    8'd21,   4'd3,  7,   0, 1'b0, 1'b0);
    do_case("dm21_4",   8'hEB,   4'd4,  -5,  -1, 1'b0, 1'b0);
    do_case("d100_m7",  8'd100,  4'h9,  -14, 2, 1'b0, 1'b0);
    do_case("dm100_m7", 8'h9C,   4'h9,  14,  -2, 1'b0, 1'b0);
    do_case("d50_0",    8'd50,   4'd0,  0,   0, 1'b1, 1'b0);
    do_case("dm128_m1", 8'h80,   4'hF,  -128, 0, 1'b0, 1'b1);
    do_case("dm128_1",  8'h80,   4'd1,  -128, 0, 1'b0, 1'b0);
    do_case("d127_m8",  8'd127,  4'h8,  -15, 7, 1'b0, 1'b0);

    // start re-pulsed during CALC with other operands must be ignored.
    @(negedge clk);
    dividend = 8'd21; divisor = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dividend = 8'd100; divisor = 4'h9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0; seen_q = '0; seen_r = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        seen_q = quotient;
        seen_r = remainder;
      end
    end
    check("restart_ndone", n_done, 1);
    check("restart_q", $signed(seen_q), 7);
    check("restart_r", $signed(seen_r), 0);
    check("restart_idle", fsm_state, IDLE);

    // Reset in the 5th CALC cycle aborts with no done pulse; reset also
    // dominates a start held at the same time.
    @(negedge clk);
    dividend = 8'd100; divisor = 4'h9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_calc", fsm_state, CALC);
    rst = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_dz", div_by_zero, 0);
    check("abort_ov", overflow, 0);
    check("abort_state", fsm_state, IDLE);
    @(posedge clk);
    #1;
    check("rst_dom_state", fsm_state, IDLE);
    rst = 1'b0; start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    do_case("after_abort", 8'hEB, 4'd4, -5, -1, 1'b0, 1'b0);

    // Round trip: a*b / b == a, remainder 0, for every a and nonzero b.
    for (int a = -8; a <= 7; a++) begin
      for (int b = -8; b <= 7; b++) begin
        if (b != 0) begin
          ai = a * b;
          p8 = ai[7:0];
          b4 = b[3:0];
          do_case("rt", p8, b4, a, 0, 1'b0, 1'b0);
        end
      end
    end

    // Random dividends: check the division identity and remainder bounds.
    for (int i = 0; i < 40; i++) begin
      a8 = 8'($urandom_range(0, 255));
      b4 = 4'($urandom_range(1, 15));
      if (a8 == 8'h80 && b4 == 4'hF) b4 = 4'd3;
      run_div(a8, b4, cyc, busy_ok, pulse_ok, q, r, dz, ov);
      a_s = a8; b_s = b4;
      ai = a_s; bi = b_s;
      qi = $signed(q); ri = $signed(r);
      check("inv_lat", cyc, 10);
      check("inv_eq", qi * bi + ri, ai);
      check("inv_mag", ((ri < 0 ? -ri : ri) < (bi < 0 ? -bi : bi)) ? 1 : 0, 1);
      check("inv_sign", (ri == 0 || ((ri < 0) == (ai < 0))) ? 1 : 0, 1);
      check("inv_flags", {dz, ov}, 0);
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
